// File: rtl/maxpool.sv
// 2x2, stride-2 max pooling over a channel-major conv/ReLU buffer.
// One read is issued per cycle, and each window max is written two cycles after that window's last read.
module maxpool #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 1,
   parameter int IMG_SIZE   = 28,
   localparam int N_IN   = CHANNELS * IMG_SIZE * IMG_SIZE,
   localparam int P      = IMG_SIZE / 2,
   localparam int N_OUT  = CHANNELS * P * P,
   localparam int AW_IN  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
   localparam int AW_OUT = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   output logic [AW_IN-1:0]             conv_r_addr,
   output logic                         conv_r_en,
   input  logic signed [DATA_WIDTH-1:0] conv_r_q,
   output logic [AW_OUT-1:0]            pool_w_addr,
   output logic                         pool_w_en,
   output logic                         pool_w_we,
   output logic signed [DATA_WIDTH-1:0] pool_w_d,
   output logic                         done
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PW = (P > 1) ? $clog2(P) : 1;

   if (IMG_SIZE % 2 != 0) begin : g_img_odd
      $error("maxpool: IMG_SIZE must be even");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                ch_q, ch_d;
   logic [PW-1:0]                pr_q, pr_d, pc_q, pc_d;
   logic [1:0]                   el_q, el_d;
   logic [AW_IN-1:0]             rd_addr_q, rd_addr_d;
   logic                         rd_en_q, rd_en_d;
   logic                         dv_q, dv_d, df_q, df_d, dl_q, dl_d;
   logic [AW_OUT-1:0]            dwin_q, dwin_d;
   logic signed [DATA_WIDTH-1:0] acc_q, acc_d, max_now;
   logic [AW_OUT-1:0]            wr_addr_q, wr_addr_d;
   logic signed [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                         wr_en_q, wr_en_d;
   logic                         done_q, done_d;
   logic                         last_rd;

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      pr_d      = pr_q;
      pc_d      = pc_q;
      el_d      = el_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      done_d    = 1'b0;
      last_rd   = (int'(ch_q) == CHANNELS - 1) && (int'(pr_q) == P - 1) &&
                  (int'(pc_q) == P - 1) && (el_q == 2'd3);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               rd_en_d = 1'b1;
               ch_d    = '0;
               pr_d    = '0;
               pc_d    = '0;
               el_d    = '0;
            end
         end
         S_RUN: begin
            if (last_rd) begin
               state_d = S_DRAIN;
            end else begin
               rd_en_d = 1'b1;
               el_d    = el_q + 2'd1;
               if (el_q == 2'd3) begin
                  if (int'(pc_q) == P - 1) begin
                     pc_d = '0;
                     if (int'(pr_q) == P - 1) begin
                        pr_d = '0;
                        ch_d = ch_q + 1'b1;
                     end else begin
                        pr_d = pr_q + 1'b1;
                     end
                  end else begin
                     pc_d = pc_q + 1'b1;
                  end
               end
            end
         end
         S_DRAIN: begin
            // Only the final window's write can land while draining.
            if (wr_en_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (rd_en_d) begin
         rd_addr_d = AW_IN'(int'(ch_d) * IMG_SIZE * IMG_SIZE
                          + (2 * int'(pr_d) + int'(el_d[1])) * IMG_SIZE
                          + 2 * int'(pc_d) + int'(el_d[0]));
      end

      // Tags travel with the read so they line up with conv_r_q one cycle later.
      dv_d   = rd_en_q;
      df_d   = (el_q == 2'd0);
      dl_d   = (el_q == 2'd3);
      dwin_d = AW_OUT'(int'(ch_q) * P * P + int'(pr_q) * P + int'(pc_q));

      max_now   = (df_q || (conv_r_q > acc_q)) ? conv_r_q : acc_q;
      acc_d     = acc_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (dv_q) begin
         acc_d = max_now;
         if (dl_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dwin_q;
            wr_data_d = max_now;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         pr_q      <= '0;
         pc_q      <= '0;
         el_q      <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         dv_q      <= 1'b0;
         df_q      <= 1'b0;
         dl_q      <= 1'b0;
         dwin_q    <= '0;
         acc_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         pr_q      <= pr_d;
         pc_q      <= pc_d;
         el_q      <= el_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         dv_q      <= dv_d;
         df_q      <= df_d;
         dl_q      <= dl_d;
         dwin_q    <= dwin_d;
         acc_q     <= acc_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         done_q    <= done_d;
      end
   end

   assign conv_r_addr = rd_addr_q;
   assign conv_r_en   = rd_en_q;
   assign pool_w_addr = wr_addr_q;
   assign pool_w_en   = wr_en_q;
   assign pool_w_we   = wr_en_q;
   assign pool_w_d    = wr_data_q;
   assign done        = done_q;
endmodule

// File: tb/tb_maxpool.sv
// Bench for maxpool (2 channels, 4x4 maps): a table of hand-computed windows, directed corner sequences,
// and random passes, checked by a stream monitor and a window-max reference model.
module tb_maxpool;
   localparam int DW    = 16;
   localparam int C     = 2;
   localparam int IMG   = 4;
   localparam int P     = IMG / 2;
   localparam int N_IN  = C * IMG * IMG;
   localparam int N_OUT = C * P * P;
   localparam int AWI   = $clog2(N_IN);
   localparam int AWO   = $clog2(N_OUT);

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic [AWI-1:0]       conv_r_addr;
   logic                 conv_r_en;
   logic signed [DW-1:0] conv_r_q = '0;
   logic [AWO-1:0]       pool_w_addr;
   logic                 pool_w_en;
   logic                 pool_w_we;
   logic signed [DW-1:0] pool_w_d;
   logic                 done;

   logic signed [DW-1:0] conv_mem [N_IN];
   logic signed [DW-1:0] pool_mem [N_OUT];
   logic signed [DW-1:0] golden   [N_OUT];
   int                   rd_seq   [N_IN];

   typedef struct {
      logic signed [DW-1:0] win [4];
      logic signed [DW-1:0] exp;
   } vec_t;
   vec_t vecs [N_OUT];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   ridx = 0, widx = 0, done_cnt = 0;
   int   first_rd_cyc = 0, last_wr_cyc = 0, last_done_cyc = 0, prev_done_cyc = 0;
   logic prev_done = 1'b0;
   int   q4 [$];

   always #5 clk = ~clk;

   maxpool #(.DATA_WIDTH(DW), .CHANNELS(C), .IMG_SIZE(IMG)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .conv_r_addr (conv_r_addr),
      .conv_r_en   (conv_r_en),
      .conv_r_q    (conv_r_q),
      .pool_w_addr (pool_w_addr),
      .pool_w_en   (pool_w_en),
      .pool_w_we   (pool_w_we),
      .pool_w_d    (pool_w_d),
      .done        (done)
   );

   // Block-RAM models: registered read, synchronous write.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (conv_r_en) conv_r_q <= conv_mem[conv_r_addr];
      if (pool_w_en && pool_w_we) pool_mem[pool_w_addr] <= pool_w_d;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event not expected or bound expired", name);
   endtask

   // Stream monitor: read order, write timing/address/data, and done placement.
   always @(negedge clk) begin
      if (conv_r_en) begin
         if (ridx % N_IN == 0) first_rd_cyc = cyc;
         check("rd_addr", int'(conv_r_addr), rd_seq[ridx % N_IN]);
         if (ridx % 4 == 3) q4.push_back(cyc);
         ridx++;
      end
      if (pool_w_en) begin
         check("w_we", int'(pool_w_we), 1);
         if (q4.size() == 0) fail_now("w_unexpected");
         else check("w_time", cyc, q4.pop_front() + 2);
         check("w_addr", int'(pool_w_addr), widx % N_OUT);
         check("w_data", int'(pool_w_d), int'(golden[widx % N_OUT]));
         last_wr_cyc = cyc;
         widx++;
      end
      if (done) begin
         check("done_strobes", int'({conv_r_en, pool_w_en, pool_w_we}), 0);
         check("done_time", cyc, last_wr_cyc + 1);
         if (prev_done) fail_now("done_width");
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         done_cnt++;
      end
      prev_done = done;
   end

   function automatic int in_addr(input int w, input int dy, input int dx);
      int c  = w / (P * P);
      int pr = (w / P) % P;
      int pc = w % P;
      return c * IMG * IMG + (2 * pr + dy) * IMG + 2 * pc + dx;
   endfunction

   task automatic begin_pass();
      for (int w = 0; w < N_OUT; w++) begin
         int m = -(1 << 30);
         for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
               if (int'(conv_mem[in_addr(w, dy, dx)]) > m) m = int'(conv_mem[in_addr(w, dy, dx)]);
         golden[w]   = DW'(m);
         pool_mem[w] = ~golden[w];
      end
      ridx = 0;
      widx = 0;
      q4.delete();
   endtask

   task automatic wait_done(input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (done_cnt > base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_pass(input string tag);
      int base, sc;
      bit ok;
      begin_pass();
      base = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      sc = cyc;
      wait_done(base, ok);
      if (!ok) fail_now({tag, "_timeout"});
      else begin
         check({tag, "_first_rd"}, first_rd_cyc, sc);
         check({tag, "_latency"}, last_done_cyc, sc + N_IN + 2);
      end
      repeat (2) @(posedge clk);
      check({tag, "_reads"}, ridx, N_IN);
      check({tag, "_writes"}, widx, N_OUT);
      for (int w = 0; w < N_OUT; w++) check({tag, "_pool"}, int'(pool_mem[w]), int'(golden[w]));
      $display("[TB] pass %s: %0d reads, %0d writes", tag, ridx, widx);
   endtask

   task automatic set_vec(input int i, input int a, input int b, input int c, input int d, input int e);
      vecs[i].win[0] = DW'(a);
      vecs[i].win[1] = DW'(b);
      vecs[i].win[2] = DW'(c);
      vecs[i].win[3] = DW'(d);
      vecs[i].exp    = DW'(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, base, snap;
      int t1_exp [N_OUT];
      bit ok;

      k = 0;
      for (int c = 0; c < C; c++)
         for (int pr = 0; pr < P; pr++)
            for (int pc = 0; pc < P; pc++)
               for (int dy = 0; dy < 2; dy++)
                  for (int dx = 0; dx < 2; dx++) begin
                     rd_seq[k] = c * IMG * IMG + (2 * pr + dy) * IMG + 2 * pc + dx;
                     k++;
                  end
      for (int i = 0; i < N_IN; i++) conv_mem[i] = '0;
      for (int w = 0; w < N_OUT; w++) golden[w] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_en", int'(conv_r_en), 0);
      check("rst_w_en", int'(pool_w_en), 0);
      check("rst_w_we", int'(pool_w_we), 0);
      check("rst_done", int'(done), 0);
      check("rst_rd_addr", int'(conv_r_addr), 0);
      check("rst_w_addr", int'(pool_w_addr), 0);
      check("rst_w_d", int'(pool_w_d), 0);
      reset = 1'b0;

      // T1: ramp data
      t1_exp = '{5, 7, 13, 15, 21, 23, 29, 31};
      for (int i = 0; i < N_IN; i++) conv_mem[i] = DW'(i);
      run_pass("t1");
      for (int w = 0; w < N_OUT; w++) check("t1_const", int'(pool_mem[w]), t1_exp[w]);

      // T2 and signed edge cases: table of windows with hand-computed maxima
      set_vec(0, -4, -1, -3, -2, -1);
      set_vec(1, -32768, 32767, 0, -1, 32767);
      set_vec(2, 7, 7, 7, 7, 7);
      set_vec(3, 100, 99, -100, 50, 100);
      set_vec(4, -5, -6, -7, 3, 3);
      set_vec(5, -32768, -32768, -32768, -32768, -32768);
      set_vec(6, 0, -1, -32768, -2, 0);
      set_vec(7, 1, -32768, 2, -32767, 2);
      for (int w = 0; w < N_OUT; w++)
         for (int e = 0; e < 4; e++) conv_mem[in_addr(w, e / 2, e % 2)] = vecs[w].win[e];
      run_pass("t2");
      for (int w = 0; w < N_OUT; w++) check("t2_table", int'(pool_mem[w]), int'(vecs[w].exp));

      // T3: checkerboards, ch0 of 1/-1 and ch1 of -32768/32767
      for (int c = 0; c < C; c++)
         for (int r = 0; r < IMG; r++)
            for (int q = 0; q < IMG; q++)
               if (c == 0) conv_mem[c * IMG * IMG + r * IMG + q] = ((r + q) % 2 == 0) ? DW'(1) : DW'(-1);
               else        conv_mem[c * IMG * IMG + r * IMG + q] = ((r + q) % 2 == 0) ? DW'(-32768) : DW'(32767);
      run_pass("t3");
      for (int w = 0; w < N_OUT; w++) check("t3_const", int'(pool_mem[w]), (w < P * P) ? 1 : 32767);

      // T4: reset ten cycles into a pass, then a clean full pass
      for (int i = 0; i < N_IN; i++) conv_mem[i] = DW'($urandom);
      begin_pass();
      base = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("t4_rd_en", int'(conv_r_en), 0);
      check("t4_w_en", int'(pool_w_en), 0);
      check("t4_done", int'(done), 0);
      check("t4_rd_addr", int'(conv_r_addr), 0);
      snap = ridx;
      repeat (20) @(posedge clk);
      check("t4_no_done", done_cnt, base);
      check("t4_no_reads", ridx, snap);
      for (int i = 0; i < N_IN; i++) conv_mem[i] = DW'($urandom);
      run_pass("t4b");

      // T5: start held high through DONE gives exactly one extra pass
      for (int i = 0; i < N_IN; i++) conv_mem[i] = DW'($urandom);
      begin_pass();
      base = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      wait_done(base, ok);
      if (!ok) fail_now("t5_first_timeout");
      @(posedge clk); #1 start = 1'b0;
      wait_done(base + 1, ok);
      if (!ok) fail_now("t5_second_timeout");
      repeat (12) @(posedge clk);
      check("t5_done_count", done_cnt, base + 2);
      check("t5_reads", ridx, 2 * N_IN);
      check("t5_writes", widx, 2 * N_OUT);
      check("t5_done_gap", last_done_cyc - prev_done_cyc, N_IN + 4);
      for (int w = 0; w < N_OUT; w++) check("t5_pool", int'(pool_mem[w]), int'(golden[w]));
      $display("[TB] pass t5: %0d reads, %0d writes", ridx, widx);

      // T6: random passes, biased toward the signed extremes
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < N_IN; i++) begin
            case ($urandom_range(0, 5))
               0:       conv_mem[i] = DW'(-32768);
               1:       conv_mem[i] = DW'(32767);
               2:       conv_mem[i] = DW'(int'($urandom_range(0, 6)) - 3);
               default: conv_mem[i] = DW'($urandom);
            endcase
         end
         run_pass($sformatf("t6_%0d", p));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
